// File: rtl/ctx_report_arbiter.sv
// ctx_report_arbiter
//   Round-robin arbiter sharing one report sink between NUM_REQ contexts.
//   A winning context's data word is latched, issued to the sink with a
//   valid/ready handshake, and then acknowledged with a one-cycle ack pulse.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req        : per-context request level (hold until ack)
//   req_data   : per-context data, context i at [i*DATA_W +: DATA_W]
//   gnt        : one-hot registered grant (ISSUE state)
//   ack        : one-hot one-cycle completion pulse (DONE state)
//   out_valid  : sink data valid
//   out_data   : latched data of the granted context
//   out_src    : index of the granted context
//   out_ready  : sink accepts the word
//   busy       : high whenever the arbiter is not idle
module ctx_report_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [ID_W-1:0]            out_src,
  input  logic                       out_ready,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]     out_src_q, out_src_d;

  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [ID_W-1:0]     cand;
  int unsigned         idx;

  // Round-robin pick: first set request scanning upward from ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          out_data_d       = req_data[win_idx*DATA_W +: DATA_W];
          out_src_d        = win_idx;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          state_d          = DONE;
          gnt_d            = '0;
          ack_d[out_src_q] = 1'b1;
          ptr_d            = (out_src_q == ID_W'(NUM_REQ - 1)) ? '0 : out_src_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      out_data_q <= '0;
      out_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign out_valid = (state_q == ISSUE);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ctx_report_arbiter.sv
// tb_ctx_report_arbiter
//   Directed bench for ctx_report_arbiter: a 2-context instance (32-bit data)
//   and a 4-context instance (8-bit data) sharing clock and reset.
module tb_ctx_report_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [1:0]  req = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  gnt, ack;
  logic        out_valid, out_ready = 1'b0, busy;
  logic [31:0] out_data;
  logic        out_src;

  logic [3:0]  req4 = '0;
  logic [31:0] req_data4 = '0;
  logic [3:0]  gnt4, ack4;
  logic        out_valid4, out_ready4 = 1'b0, busy4;
  logic [7:0]  out_data4;
  logic [1:0]  out_src4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ctx_report_arbiter #(.NUM_REQ(2), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .ack(ack),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  ctx_report_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .req_data(req_data4), .gnt(gnt4), .ack(ack4),
    .out_valid(out_valid4), .out_data(out_data4), .out_src(out_src4),
    .out_ready(out_ready4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the 2-context instance; data/src only compared while valid.
  task automatic chk2(input string tag, input logic v, input logic [31:0] d, input logic s,
                      input logic [1:0] g, input logic [1:0] a);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".gnt"},   64'(gnt),       64'(g));
    chk({tag, ".ack"},   64'(ack),       64'(a));
    chk({tag, ".busy"},  64'(busy),      64'(v | (|a)));
    if (v) begin
      chk({tag, ".data"}, 64'(out_data), 64'(d));
      chk({tag, ".src"},  64'(out_src),  64'(s));
    end
  endtask

  task automatic chk4(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s,
                      input logic [3:0] g, input logic [3:0] a);
    chk({tag, ".valid"}, 64'(out_valid4), 64'(v));
    chk({tag, ".gnt"},   64'(gnt4),       64'(g));
    chk({tag, ".ack"},   64'(ack4),       64'(a));
    chk({tag, ".busy"},  64'(busy4),      64'(v | (|a)));
    if (v) begin
      chk({tag, ".data"}, 64'(out_data4), 64'(d));
      chk({tag, ".src"},  64'(out_src4),  64'(s));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        s;
    logic [31:0] d;

    // Reset held for two edges, then idle with no requests.
    tick; tick;
    chk("rst.valid", 64'(out_valid), 64'(0));
    chk("rst.data",  64'(out_data),  64'(0));
    chk("rst.src",   64'(out_src),   64'(0));
    chk2("rst", 1'b0, 32'd0, 1'b0, 2'b00, 2'b00);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk2("idle", 1'b0, 32'd0, 1'b0, 2'b00, 2'b00);
      chk4("idle4", 1'b0, 8'd0, 2'd0, 4'b0000, 4'b0000);
    end

    // Single context 0.
    req_data = {32'd10, 32'd5};
    req = 2'b01;
    out_ready = 1'b1;
    tick; chk2("single.issue", 1'b1, 32'd5, 1'b0, 2'b01, 2'b00);
    tick; chk2("single.done",  1'b0, 32'd0, 1'b0, 2'b00, 2'b01);
    req = 2'b00;
    tick; chk2("single.idle",  1'b0, 32'd0, 1'b0, 2'b00, 2'b00);

    // Contention: ptr is now 1, so rotation starts at context 1.
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      s = (k % 2 == 0) ? 1'b1 : 1'b0;
      d = s ? 32'd10 : 32'd5;
      tick; chk2("rot.issue", 1'b1, d, s, 2'(1 << s), 2'b00);
      tick; chk2("rot.done",  1'b0, d, s, 2'b00, 2'(1 << s));
      tick; chk2("rot.idle",  1'b0, d, s, 2'b00, 2'b00);
    end
    req = 2'b00;
    tick; chk2("rot.quiet", 1'b0, 32'd0, 1'b0, 2'b00, 2'b00);

    // Backpressure on context 1 (ptr=1); req/data changes are ignored while issuing.
    req = 2'b10;
    out_ready = 1'b0;
    tick; chk2("bp.issue", 1'b1, 32'd10, 1'b1, 2'b10, 2'b00);
    req = 2'b01;
    req_data = {32'hDEAD_BEEF, 32'd5};
    for (int i = 0; i < 6; i++) begin
      tick; chk2("bp.hold", 1'b1, 32'd10, 1'b1, 2'b10, 2'b00);
    end
    req = 2'b00;
    req_data = {32'd10, 32'd5};
    out_ready = 1'b1;
    tick; chk2("bp.done", 1'b0, 32'd0, 1'b0, 2'b00, 2'b10);
    tick; chk2("bp.idle", 1'b0, 32'd0, 1'b0, 2'b00, 2'b00);

    // Complete context 0 (ptr -> 1), then start context 1 and reset mid-issue.
    req = 2'b01;
    tick; chk2("pre.issue", 1'b1, 32'd5, 1'b0, 2'b01, 2'b00);
    req = 2'b00;
    tick; chk2("pre.done",  1'b0, 32'd0, 1'b0, 2'b00, 2'b01);
    req = 2'b10;
    out_ready = 1'b0;
    tick; tick; chk2("mid.issue", 1'b1, 32'd10, 1'b1, 2'b10, 2'b00);
    rst = 1'b1;
    #1;
    chk("mid.rst.data", 64'(out_data), 64'(0));
    chk2("mid.rst", 1'b0, 32'd0, 1'b0, 2'b00, 2'b00);
    out_ready = 1'b1;
    tick; chk2("mid.rst.hold", 1'b0, 32'd0, 1'b0, 2'b00, 2'b00);
    // Both requesting: ptr reset to 0 so context 0 wins.
    req = 2'b11;
    rst = 1'b0;
    tick; chk2("post.issue", 1'b1, 32'd5, 1'b0, 2'b01, 2'b00);
    req = 2'b00;
    tick; chk2("post.done",  1'b0, 32'd0, 1'b0, 2'b00, 2'b01);
    tick; chk2("post.idle",  1'b0, 32'd0, 1'b0, 2'b00, 2'b00);

    // 4-context wrap: serve context 2 so ptr becomes 3, then req=1001 -> 3, 0.
    req_data4 = {8'd103, 8'd102, 8'd101, 8'd100};
    out_ready4 = 1'b1;
    req4 = 4'b0100;
    tick; chk4("w.c2.issue", 1'b1, 8'd102, 2'd2, 4'b0100, 4'b0000);
    req4 = 4'b0000;
    tick; chk4("w.c2.done",  1'b0, 8'd0, 2'd0, 4'b0000, 4'b0100);
    tick; chk4("w.c2.idle",  1'b0, 8'd0, 2'd0, 4'b0000, 4'b0000);
    req4 = 4'b1001;
    tick; chk4("w.c3.issue", 1'b1, 8'd103, 2'd3, 4'b1000, 4'b0000);
    tick; chk4("w.c3.done",  1'b0, 8'd0, 2'd0, 4'b0000, 4'b1000);
    req4 = 4'b0001;
    tick; chk4("w.c3.idle",  1'b0, 8'd0, 2'd0, 4'b0000, 4'b0000);
    tick; chk4("w.c0.issue", 1'b1, 8'd100, 2'd0, 4'b0001, 4'b0000);
    req4 = 4'b0000;
    tick; chk4("w.c0.done",  1'b0, 8'd0, 2'd0, 4'b0000, 4'b0001);
    tick; chk4("w.c0.idle",  1'b0, 8'd0, 2'd0, 4'b0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
